// File: rtl/snake_pkg.sv
// Shared snake game constants, bus geometry and encodings.
// Imported by the box generator and the snake core.
package snake_pkg;

    localparam int X0    = 70;
    localparam int Y0    = 62;
    localparam int STEP  = 15;
    localparam int ROWS  = 61;

    localparam int SEG_W  = 11;
    localparam int SEGS   = 20;
    localparam int BODY_W = SEG_W * SEGS;

    localparam logic [SEG_W-1:0] EMPTY_SEG = 11'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_CHECK
    } box_state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Shifts every cycle; reset loads SEED (must be nonzero).
module snake_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    output logic [15:0] O_state
);

    logic [15:0] state_q;
    logic        fb;

    assign fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= {state_q[14:0], fb};
        end
    end

    assign O_state = state_q;

endmodule

// File: rtl/snake_box_gen.sv
// Food-box generator: draws random grid cells, rejects cells under
// the snake body, and publishes the accepted cell to core/renderer.
module snake_box_gen
    import snake_pkg::*;
#(
    parameter int          X0   = snake_pkg::X0,
    parameter int          Y0   = snake_pkg::Y0,
    parameter int          STEP = snake_pkg::STEP,
    parameter int          ROWS = snake_pkg::ROWS,
    parameter int          SEGS = snake_pkg::SEGS,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_drive,
    input  logic [SEGS*SEG_W-1:0]   I_snake_body_x,
    input  logic [SEGS*SEG_W-1:0]   I_snake_body_y,
    output logic [9:0]              O_box_x,
    output logic [9:0]              O_box_y,
    output logic                    O_box_valid,
    output logic                    O_busy
);

    localparam int IDX_W = (SEGS > 1) ? $clog2(SEGS) : 1;

    localparam logic [10:0]      X0_L   = 11'(X0);
    localparam logic [10:0]      Y0_L   = 11'(Y0);
    localparam logic [10:0]      STEP_L = 11'(STEP);
    localparam logic [10:0]      ROWS_L = 11'(ROWS);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(SEGS - 1);

    logic [15:0] lfsr;

    snake_lfsr16 #(.SEED(SEED)) u_lfsr (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .O_state (lfsr)
    );

    logic [10:0] col_w;
    logic [10:0] row_w;
    logic [10:0] x_full;
    logic [10:0] y_full;
    logic        row_ok;

    assign col_w  = {5'b0, lfsr[5:0]};
    assign row_w  = {5'b0, lfsr[11:6]};
    assign x_full = X0_L + col_w * STEP_L;
    assign y_full = Y0_L + row_w * STEP_L;
    assign row_ok = row_w < ROWS_L;

    logic unused_bits;
    assign unused_bits = ^{lfsr[15:12], x_full[10], y_full[10]};

    box_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [9:0]       cx_q;
    logic [9:0]       cy_q;
    logic [9:0]       box_x_q;
    logic [9:0]       box_y_q;
    logic             valid_q;
    logic             busy_q;

    logic [SEG_W-1:0] seg_x;
    logic [SEG_W-1:0] seg_y;
    logic             hit;

    // Body is read live each CHECK cycle, one segment per cycle.
    always_comb begin
        seg_x = EMPTY_SEG;
        seg_y = EMPTY_SEG;
        for (int k = 0; k < SEGS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                seg_x = I_snake_body_x[k*SEG_W +: SEG_W];
                seg_y = I_snake_body_y[k*SEG_W +: SEG_W];
            end
        end
    end

    assign hit = (seg_x == {1'b0, cx_q}) && (seg_y == {1'b0, cy_q});

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_DRAW;
            idx_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            box_x_q <= '0;
            box_y_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Parked y=0 keeps the core's eat window off-grid.
                    if (I_drive) begin
                        state_q <= ST_DRAW;
                        valid_q <= 1'b0;
                        box_y_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (row_ok) begin
                        cx_q    <= x_full[9:0];
                        cy_q    <= y_full[9:0];
                        idx_q   <= '0;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        state_q <= ST_DRAW;
                    end else if (idx_q == LAST) begin
                        box_x_q <= cx_q;
                        box_y_q <= cy_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_DRAW;
                end
            endcase
        end
    end

    assign O_box_x     = box_x_q;
    assign O_box_y     = box_y_q;
    assign O_box_valid = valid_q;
    assign O_busy      = busy_q;

endmodule

// File: tb/tb_snake_box_gen.sv
// Scoreboard bench for snake_box_gen: a timeline model of the search
// predicts each commit (cell and edge); a monitor checks every commit.
module tb_snake_box_gen;

    localparam int NLF = 20000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         drive = 1'b0;
    logic [219:0] body_x;
    logic [219:0] body_y;
    logic [9:0]   box_x;
    logic [9:0]   box_y;
    logic         box_valid;
    logic         busy;

    logic [10:0] bx [20];
    logic [10:0] by [20];
    logic [15:0] lf [NLF];

    typedef struct {
        int e;
        int x;
        int y;
    } exp_t;

    exp_t sbq [$];
    exp_t ex;
    int   checks = 0;
    int   errors = 0;
    int   ecnt;
    logic prev_v = 1'b0;

    snake_box_gen dut (
        .I_clk          (clk),
        .I_rst_n        (rst_n),
        .I_drive        (drive),
        .I_snake_body_x (body_x),
        .I_snake_body_y (body_y),
        .O_box_x        (box_x),
        .O_box_y        (box_y),
        .O_box_valid    (box_valid),
        .O_busy         (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 20; k++) begin
            body_x[k*11 +: 11] = bx[k];
            body_y[k*11 +: 11] = by[k];
        end
    end

    // Edges since the last reset release; edge n samples lf[n-1].
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic int lf_at(input int n);
        if (n < 1 || n > NLF) return 0;
        return int'(lf[n-1]);
    endfunction

    // Search starting with DRAW at edge d0: illegal row costs 1,
    // collision at segment k costs k+2, clean cell commits 20 later.
    function automatic void predict(input int d0, output exp_t r);
        int d = d0;
        int v, col, row, x, y, hk;
        r.e = -1; r.x = 0; r.y = 0;
        for (int g = 0; g < 2000; g++) begin
            v   = lf_at(d);
            col = v & 63;
            row = (v >> 6) & 63;
            if (row >= 61) begin
                d++;
            end else begin
                x  = 70 + col * 15;
                y  = 62 + row * 15;
                hk = -1;
                for (int k = 0; k < 20; k++)
                    if (hk < 0 && int'(bx[k]) == x && int'(by[k]) == y) hk = k;
                if (hk < 0) begin
                    r.e = d + 20; r.x = x; r.y = y;
                    return;
                end
                d += hk + 2;
            end
        end
    endfunction

    function automatic void first_cand(input int d0, output int x, output int y);
        int v;
        x = 0; y = 0;
        for (int d = d0; d < d0 + 2000; d++) begin
            v = lf_at(d);
            if (((v >> 6) & 63) < 61) begin
                x = 70 + (v & 63) * 15;
                y = 62 + ((v >> 6) & 63) * 15;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (box_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got x=%0d y=%0d at edge %0d expected none",
                             box_x, box_y, ecnt);
                end else begin
                    ex = sbq.pop_front();
                    chk("commit_edge", ecnt, ex.e);
                    chk("box_x", int'(box_x), ex.x);
                    chk("box_y", int'(box_y), ex.y);
                    chk("busy_at_commit", int'(busy), 0);
                    chk("x_on_grid", (int'(box_x) - 70) % 15, 0);
                    chk("y_on_grid", (int'(box_y) - 62) % 15, 0);
                    chk("x_le_1015", int'(box_x <= 10'd1015), 1);
                    chk("y_le_962", int'(box_y <= 10'd962), 1);
                end
            end
            prev_v = box_valid;
        end
    end

    task automatic wait_commit();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) return;
        end
        chk("commit_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_empty();
        for (int k = 0; k < 20; k++) begin
            bx[k] = 11'h7FF;
            by[k] = 11'h7FF;
        end
    endtask

    // Pulse drive so edge E samples it; DRAW is at E+1.
    task automatic drive_box();
        int   e;
        int   old_x;
        exp_t r;
        old_x = int'(box_x);
        e = ecnt + 1;
        predict(e + 1, r);
        sbq.push_back(r);
        drive = 1'b1;
        @(negedge clk);
        drive = 1'b0;
        chk("drv_valid_low", int'(box_valid), 0);
        chk("drv_y_parked", int'(box_y), 0);
        chk("drv_x_held", int'(box_x), old_x);
        chk("drv_busy", int'(busy), 1);
        #1;
    endtask

    task automatic release_reset();
        exp_t r;
        @(negedge clk);
        rst_n = 1'b1;
        predict(1, r);
        sbq.push_back(r);
        #1;
        chk("release_busy", int'(busy), 1);
        chk("release_valid", int'(box_valid), 0);
    endtask

    initial begin
        int   x, y, k, mode, n;
        exp_t r;

        lf[0] = 16'hACE1;
        for (int i = 1; i < NLF; i++)
            lf[i] = {lf[i-1][14:0], lf[i-1][15] ^ lf[i-1][13] ^ lf[i-1][12] ^ lf[i-1][10]};
        set_empty();

        #12;
        chk("rst_x", int'(box_x), 0);
        chk("rst_y", int'(box_y), 0);
        chk("rst_valid", int'(box_valid), 0);
        chk("rst_busy", int'(busy), 1);
        release_reset();
        wait_commit();

        // Mixed random searches: empty body, random body, forced collision.
        for (int it = 0; it < 12; it++) begin
            idle_cycles($urandom_range(1, 15));
            set_empty();
            mode = $urandom_range(0, 2);
            if (mode == 1) begin
                for (int s = 0; s < 20; s++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bx[s] = 11'(70 + 15 * $urandom_range(0, 63));
                        by[s] = 11'(62 + 15 * $urandom_range(0, 60));
                    end
                end
            end else if (mode == 2) begin
                k = (it % 3 == 0) ? 7 : $urandom_range(0, 19);
                first_cand(ecnt + 2, x, y);
                bx[k] = 11'(x);
                by[k] = 11'(y);
            end
            drive_box();
            wait_commit();
        end

        // Wait until the DRAW sample holds an illegal row (61..63).
        set_empty();
        idle_cycles(1);
        n = 0;
        while ((((lf_at(ecnt + 2) >> 6) & 63) < 61) && n < 2000) begin
            idle_cycles(1);
            n++;
        end
        chk("illegal_row_found", int'(n < 2000), 1);
        drive_box();
        wait_commit();

        // Reset while CHECK sits at idx 10.
        idle_cycles(2);
        n = 0;
        while ((((lf_at(ecnt + 2) >> 6) & 63) >= 61) && n < 200) begin
            idle_cycles(1);
            n++;
        end
        drive_box();
        while (ecnt < sbq[0].e - 10) @(negedge clk);
        #1;
        chk("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        sbq.delete();
        chk("abort_x", int'(box_x), 0);
        chk("abort_y", int'(box_y), 0);
        chk("abort_valid", int'(box_valid), 0);
        chk("abort_busy", int'(busy), 1);
        idle_cycles(3);
        release_reset();
        wait_commit();

        // Drive pulse during an active search must be ignored.
        idle_cycles(4);
        drive_box();
        idle_cycles(8);
        drive = 1'b1;
        @(negedge clk);
        drive = 1'b0;
        wait_commit();
        idle_cycles(60);
        chk("no_second_search_busy", int'(busy), 0);
        chk("no_second_search_valid", int'(box_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_box_gen.md
# snake_box_gen

Food-box generator for the snake game, directly upstream of the snake core. It produces the box coordinates the core compares against the snake head. When the core pulses its drive output, this block draws a new pseudo-random grid cell, rejects cells occupied by any live snake segment, and publishes the accepted cell. A `valid` flag tells the renderer when the box may be drawn.

## Interface
Parameters:
- `X0`, default 70: x pixel of grid column 0.
- `Y0`, default 62: y pixel of grid row 0.
- `STEP`, default 15: grid pitch in pixels.
- `ROWS`, default 61: number of legal rows, 0..60.
- `SEGS`, default 20: number of snake segments in the packed body buses.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports (reset `I_rst_n`, asynchronous, active-low; clock `I_clk`):
- `I_clk`  in  1  clock.
- `I_rst_n`  in  1  asynchronous active-low reset.
- `I_drive`  in  1  one-cycle pulse from the snake core: box eaten, request new box.
- `I_snake_body_x`  in  220  packed segment x coordinates; segment k at [11k+10:11k]; unused segments are 11'h7FF.
- `I_snake_body_y`  in  220  packed segment y coordinates, same packing as x.
- `O_box_x`  out  10  box centre x pixel.
- `O_box_y`  out  10  box centre y pixel; 0 while parked.
- `O_box_valid`  out  1  box committed and drawable.
- `O_busy`  out  1  search in progress.

## Operation
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every cycle (free-running), resets to `SEED`.
- Candidate: col = lfsr[5:0] (0..63), row = lfsr[11:6].
  - Row >= `ROWS` is rejected; a new sample is taken next cycle.
  - x = X0 + col*STEP, computed as (col<<4)-col; maximum 1015, so it fits 10 bits.
  - y = Y0 + row*STEP; maximum 962.
- FSM states: IDLE, DRAW, CHECK.
- IDLE:
  - `I_drive`=1 → DRAW; `O_box_valid`←0, `O_box_y`←0 (parked), `O_busy`←1.
  - `O_box_x` holds its value.
- DRAW:
  - Row legal → register the candidate, seg index←0, → CHECK.
  - Otherwise stay in DRAW.
- CHECK: compare the zero-extended candidate against segment[idx] on both x and y (11-bit compares).
  - Match → DRAW.
  - No match and idx<SEGS-1 → idx+1.
  - No match and idx=SEGS-1 → load `O_box_x`/`O_box_y`, `O_box_valid`←1, `O_busy`←0, → IDLE.
- Body buses are sampled live each CHECK cycle; no snapshot is taken.
- `I_drive` is ignored outside IDLE.
- Parked y=0 guarantees no false eat in the core: 11-bit arithmetic puts the window at 2041..7, which contains no head y.
- Unused segments (11'h7FF) and the all-ones dead pattern never match the grid.

## Timing
- Reset values: `O_box_x`=0, `O_box_y`=0, `O_box_valid`=0, `O_busy`=1, state=DRAW, lfsr=`SEED`, idx=0.
- After reset the block immediately searches for the first box.
- Latency from the `I_drive` sample edge E to `O_box_valid` high:
  - Minimum is 21 cycles: DRAW at E+1, CHECK idx 0..19 at E+2..E+21, commit on E+21.
  - Each rejected row adds 1 cycle.
  - Each collision at idx k adds k+2 cycles.
- `O_box_valid` and `O_busy` are mutually exclusive, registered, and glitch-free.
- Reset asserted mid-search aborts immediately to the reset values above.
- `I_drive` coincident with commit cannot occur, because `I_drive` is only sampled in IDLE.

## Structure
- Shared `snake_pkg`:
  - grid constants X0/Y0/STEP/ROWS;
  - SEG_W=11, SEGS=20, EMPTY_SEG=11'h7FF;
  - body bus width 220;
  - FSM state enum;
  - direction encodings shared with the core.
- One sub-module: `snake_lfsr16`, with a seed parameter, free-running, 16-bit state output.

## Test plan
- Reset release with the body bus all ones: `O_busy`=1 at release; commit occurs at the cycle predicted by the LFSR model from `SEED`; (x−70)%15=0, (y−62)%15=0, x≤1015, y≤962.
- Idle, then `I_drive` pulse: next cycle `O_box_valid`=0, `O_box_y`=0, `O_box_x` held; new box valid ≥21 cycles later, matching the model.
- Segment 7 set to the model's first candidate: candidate rejected at idx 7; the committed box is the next model candidate, with latency +9 cycles.
- LFSR state forcing row 61..63 at the DRAW sample: no CHECK entry that cycle; 1 extra cycle of latency.
- Reset asserted at CHECK idx 10: outputs return to 0/0/0/1 asynchronously; on release, the search restarts from `SEED`.
- `I_drive` pulsed during a search: ignored; exactly one commit, and no second search starts.
